// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the memory-stage load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Writeback select, shared with the MEM/WB register and the WB mux
    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_MEM = 2'b01;
    localparam logic [1:0] RS_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - data-memory request/grant/rvalid bus
interface mem_stage_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane/byte-enable generation and load extraction
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (st_size)
            2'b00: begin
                be    = 4'b0001 << st_off;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << st_off;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending
    assign shifted = rdata >> {ld_off, 3'b000};

    always_comb begin
        load_data = shifted;
        case (ld_funct3)
            F3_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU: load_data = {24'h0, shifted[7:0]};
            F3_LHU: load_data = {16'h0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32I memory-stage LSU; LSU_STATS_EN adds access/stall counters
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
`ifdef LSU_STATS_EN
    , parameter int STAT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            mem_rd,
    input  logic            mem_wr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_addr,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd_in,
    input  logic            reg_wrt_in,
    input  logic [1:0]      rslt_src_in,
    input  logic [XLEN-1:0] pc4_in,
    output logic            mem_stall,
    output logic            wb_valid,
    output logic [XLEN-1:0] read_data,
    output logic [XLEN-1:0] alu_out,
    output logic [4:0]      rd_out,
    output logic            reg_wrt_out,
    output logic [1:0]      rslt_src_out,
    output logic [XLEN-1:0] pc4_out,
    output logic            misalign_exc,
    mem_stage_lsu_if.master dmem
`ifdef LSU_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_loads,
    output logic [STAT_W-1:0] stat_stores,
    output logic [STAT_W-1:0] stat_stall_cycles
`endif
);

    lsu_state_t  state, state_nx;
    logic [2:0]  ld_f3_q;
    logic [1:0]  ld_off_q;
    logic        latch;
    logic        req;
    logic        is_mem;
    logic        misaligned;
    logic        load_done;
    logic        store_done;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] load_data;

    assign is_mem     = mem_rd | mem_wr;
    assign misaligned = is_mem & (((funct3[1:0] == 2'b10) & (alu_addr[1:0] != 2'b00)) |
                                  ((funct3[1:0] == 2'b01) & alu_addr[0]));

    lsu_align u_align (
        .st_size    (funct3[1:0]),
        .st_off     (alu_addr[1:0]),
        .store_data (store_data),
        .be         (be_c),
        .wdata      (wdata_c),
        .ld_funct3  (ld_f3_q),
        .ld_off     (ld_off_q),
        .rdata      (dmem.rdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ld_f3_q  <= 3'b000;
            ld_off_q <= 2'b00;
        end else begin
            state <= state_nx;
            if (latch) begin
                ld_f3_q  <= funct3;
                ld_off_q <= alu_addr[1:0];
            end
        end
    end

    // Outputs are held quiet while reset is asserted, independent of the inputs
    always_comb begin
        state_nx     = state;
        req          = 1'b0;
        mem_stall    = 1'b0;
        wb_valid     = 1'b0;
        misalign_exc = 1'b0;
        read_data    = '0;
        latch        = 1'b0;
        load_done    = 1'b0;
        store_done   = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE, REQ: begin
                    if (!ex_valid) begin
                        state_nx = IDLE;
                    end else if (!is_mem) begin
                        wb_valid = 1'b1;
                    end else if (misaligned) begin
                        misalign_exc = 1'b1;
                        wb_valid     = 1'b1;
                        state_nx     = IDLE;
                    end else begin
                        req = 1'b1;
                        if (dmem.gnt) begin
                            if (mem_wr) begin
                                wb_valid   = 1'b1;
                                store_done = 1'b1;
                                state_nx   = IDLE;
                            end else begin
                                latch     = 1'b1;
                                mem_stall = 1'b1;
                                state_nx  = WAIT;
                            end
                        end else begin
                            mem_stall = 1'b1;
                            state_nx  = REQ;
                        end
                    end
                end
                WAIT: begin
                    if (dmem.rvalid) begin
                        wb_valid  = 1'b1;
                        read_data = load_data;
                        load_done = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        mem_stall = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign dmem.req   = req;
    assign dmem.we    = req & mem_wr;
    assign dmem.addr  = {alu_addr[31:2], 2'b00};
    assign dmem.be    = req ? be_c : 4'b0000;
    assign dmem.wdata = wdata_c;

    assign alu_out      = alu_addr;
    assign rd_out       = rd_in;
    assign rslt_src_out = rslt_src_in;
    assign pc4_out      = pc4_in;
    assign reg_wrt_out  = reg_wrt_in & wb_valid & ~misalign_exc;

`ifdef LSU_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads        <= '0;
            stat_stores       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (load_done)  stat_loads        <= stat_loads + 1'b1;
            if (store_done) stat_stores       <= stat_stores + 1'b1;
            if (mem_stall)  stat_stall_cycles <= stat_stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] alu_addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        reg_wrt_in;
    logic [1:0]  rslt_src_in;
    logic [31:0] pc4_in;
    logic        mem_stall;
    logic        wb_valid;
    logic [31:0] read_data;
    logic [31:0] alu_out;
    logic [4:0]  rd_out;
    logic        reg_wrt_out;
    logic [1:0]  rslt_src_out;
    logic [31:0] pc4_out;
    logic        misalign_exc;

    int n_checks = 0;
    int n_fail   = 0;

    int          stalls, reqs;
    logic        done, stable, f_we;
    logic [3:0]  f_be;
    logic [31:0] f_addr, f_wdata, got_data;

    mem_stage_lsu_if dmem_bus ();

    mem_stage_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .funct3       (funct3),
        .alu_addr     (alu_addr),
        .store_data   (store_data),
        .rd_in        (rd_in),
        .reg_wrt_in   (reg_wrt_in),
        .rslt_src_in  (rslt_src_in),
        .pc4_in       (pc4_in),
        .mem_stall    (mem_stall),
        .wb_valid     (wb_valid),
        .read_data    (read_data),
        .alu_out      (alu_out),
        .rd_out       (rd_out),
        .reg_wrt_out  (reg_wrt_out),
        .rslt_src_out (rslt_src_out),
        .pc4_out      (pc4_out),
        .misalign_exc (misalign_exc),
        .dmem         (dmem_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] data);
        ex_valid   = 1'b1;
        mem_rd     = rd;
        mem_wr     = wr;
        funct3     = f3;
        alu_addr   = addr;
        store_data = data;
        reg_wrt_in = rd;
        rslt_src_in = rd ? RS_MEM : RS_ALU;
    endtask

    task automatic go_idle();
        ex_valid        = 1'b0;
        mem_rd          = 1'b0;
        mem_wr          = 1'b0;
        dmem_bus.gnt    = 1'b0;
        dmem_bus.rvalid = 1'b0;
    endtask

    // Drives gnt after gnt_dly cycles and rvalid rv_dly cycles after that; bounded to 20 cycles
    task automatic run_access(input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        stalls = 0;
        reqs   = 0;
        done   = 1'b0;
        stable = 1'b1;
        got_data = 32'h0;
        for (int c = 0; c < 20; c++) begin
            dmem_bus.gnt    = (c == gnt_dly);
            dmem_bus.rvalid = (c == gnt_dly + rv_dly);
            dmem_bus.rdata  = rdata;
            @(negedge clk);
            if (c == 0) begin
                f_we = dmem_bus.we; f_be = dmem_bus.be;
                f_addr = dmem_bus.addr; f_wdata = dmem_bus.wdata;
            end
            if (dmem_bus.req) begin
                reqs++;
                if (dmem_bus.we !== f_we || dmem_bus.be !== f_be ||
                    dmem_bus.addr !== f_addr || dmem_bus.wdata !== f_wdata)
                    stable = 1'b0;
            end
            if (mem_stall) stalls++;
            if (wb_valid) begin
                done = 1'b1;
                got_data = read_data;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        go_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        go_idle();
        funct3 = F3_LW; alu_addr = 32'h0; store_data = 32'h0;
        rd_in = 5'd0; reg_wrt_in = 1'b0; rslt_src_in = RS_ALU; pc4_in = 32'h0;
        dmem_bus.rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        set_instr(1'b1, 1'b0, F3_LW, 32'h55, 32'h0);
        rd_in = 5'd9; pc4_in = 32'h44;
        @(negedge clk);
        chk("rst_req", dmem_bus.req, 0);
        chk("rst_be", dmem_bus.be, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_misalign", misalign_exc, 0);
        chk("rst_alu_out", alu_out, 32'h55);
        chk("rst_pc4_out", pc4_out, 32'h44);
        chk("rst_rd_out", rd_out, 9);
        @(posedge clk);
        #1;
        go_idle();
        rst_n = 1'b1;

        // non-memory instruction passes straight through
        ex_valid = 1'b1; reg_wrt_in = 1'b1; alu_addr = 32'h1234; rslt_src_in = RS_PC4;
        @(negedge clk);
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_stall", mem_stall, 0);
        chk("alu_reg_wrt", reg_wrt_out, 1);
        chk("alu_req", dmem_bus.req, 0);
        chk("alu_rslt_src", rslt_src_out, RS_PC4);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("bubble_wb_valid", wb_valid, 0);
        chk("bubble_reg_wrt", reg_wrt_out, 0);
        @(posedge clk);
        #1;

        // sw, granted immediately
        set_instr(1'b0, 1'b1, F3_LW, 32'h100, 32'hDEADBEEF);
        run_access(0, 1, 32'h0);
        chk("sw_done", done, 1);
        chk("sw_we", f_we, 1);
        chk("sw_addr", f_addr, 32'h100);
        chk("sw_be", f_be, 4'b1111);
        chk("sw_wdata", f_wdata, 32'hDEADBEEF);
        chk("sw_stalls", stalls, 0);

        // lb signed, gnt cycle 0, rvalid cycle 1
        set_instr(1'b1, 1'b0, F3_LB, 32'h103, 32'h0);
        run_access(0, 1, 32'h80123456);
        chk("lb_done", done, 1);
        chk("lb_addr", f_addr, 32'h100);
        chk("lb_be", f_be, 4'b1000);
        chk("lb_data", got_data, 32'hFFFFFF80);
        chk("lb_stalls", stalls, 1);

        // lhu with delayed grant
        set_instr(1'b1, 1'b0, F3_LHU, 32'h102, 32'h0);
        run_access(3, 2, 32'hBEEF1234);
        chk("lhu_done", done, 1);
        chk("lhu_req_cycles", reqs, 4);
        chk("lhu_req_stable", stable, 1);
        chk("lhu_data", got_data, 32'h0000BEEF);
        chk("lhu_stalls", stalls, 5);

        // sb lanes
        set_instr(1'b0, 1'b1, F3_LB, 32'h102, 32'h000000AB);
        run_access(1, 1, 32'h0);
        chk("sb_done", done, 1);
        chk("sb_be", f_be, 4'b0100);
        chk("sb_wdata", f_wdata, 32'hABABABAB);
        chk("sb_stalls", stalls, 1);

        // misaligned lw
        set_instr(1'b1, 1'b0, F3_LW, 32'h101, 32'h0);
        @(negedge clk);
        chk("mis_req", dmem_bus.req, 0);
        chk("mis_exc", misalign_exc, 1);
        chk("mis_reg_wrt", reg_wrt_out, 0);
        chk("mis_wb_valid", wb_valid, 1);
        chk("mis_stall", mem_stall, 0);
        @(posedge clk);
        #1;
        go_idle();
        @(negedge clk);
        chk("mis_pulse_end", misalign_exc, 0);
        @(posedge clk);
        #1;

        // reset while in WAIT, then a stray rvalid
        set_instr(1'b1, 1'b0, F3_LW, 32'h200, 32'h0);
        dmem_bus.gnt = 1'b1;
        @(negedge clk);
        chk("rwait_stall", mem_stall, 1);
        @(posedge clk);
        #1;
        dmem_bus.gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rwait_rst_stall", mem_stall, 0);
        chk("rwait_rst_req", dmem_bus.req, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        go_idle();
        dmem_bus.rvalid = 1'b1;
        dmem_bus.rdata  = 32'h12345678;
        @(negedge clk);
        chk("stray_wb_valid", wb_valid, 0);
        chk("stray_read_data", read_data, 0);
        chk("stray_stall", mem_stall, 0);
        @(posedge clk);
        #1;
        go_idle();

        // fresh lw after reset recovery
        set_instr(1'b1, 1'b0, F3_LW, 32'h104, 32'h0);
        run_access(0, 1, 32'hCAFEF00D);
        chk("lw_done", done, 1);
        chk("lw_data", got_data, 32'hCAFEF00D);
        chk("lw_stalls", stalls, 1);
        @(negedge clk);
        chk("idle_read_data", read_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit of the in-order RV32I pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register (mewb); drives the data-memory request/grant/rvalid interface.
- Aligns store data and byte enables; extracts and sign/zero-extends load data.
- Stalls the front of the pipeline until each access completes.

Parameters:
XLEN, 32, datapath/address width (only 32 supported)
STAT_W, 32, width of statistics counters (used only with LSU_STATS_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX/MEM holds a valid instruction
mem_rd  in  1  instruction is a load
mem_wr  in  1  instruction is a store
funct3  in  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
alu_addr  in  32  effective address / ALU result
store_data  in  32  rs2 value
rd_in  in  5  destination register
reg_wrt_in  in  1  register write enable
rslt_src_in  in  2  writeback select
pc4_in  in  32  PC+4
mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
wb_valid  out  1  valid instruction presented to MEM/WB this cycle
read_data  out  32  formatted load data
alu_out  out  32  alu_addr pass-through
rd_out  out  5  rd pass-through
reg_wrt_out  out  1  reg_wrt_in, gated (see Behaviour)
rslt_src_out  out  2  pass-through
pc4_out  out  32  pass-through
misalign_exc  out  1  misaligned access, one-cycle pulse
dmem_req  out  1  request
dmem_we  out  1  write
dmem_addr  out  32  word address (alu_addr with [1:0] = 0)
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-shifted store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read data

Behaviour:
- FSM states IDLE, REQ, WAIT; reset to IDLE.
- All registered state (FSM, latched funct3, latched addr[1:0]) clears to 0 on rst_n low.
- Output values while reset is asserted:
  - dmem_req=0, dmem_we=0, dmem_be=0, mem_stall=0, wb_valid=0, misalign_exc=0.
  - Pass-through outputs follow their inputs.
- Reset mid-access: FSM returns to IDLE; a later dmem_rvalid in IDLE is ignored.
- Non-memory instruction (ex_valid, !mem_rd, !mem_wr): passes through combinationally; wb_valid=1, mem_stall=0, zero added latency.
- Misaligned access: word with alu_addr[1:0]!=0, or half with alu_addr[0]=1.
  - No dmem_req is issued.
  - misalign_exc=1 for one cycle, reg_wrt_out=0, wb_valid=1, mem_stall=0.
- Aligned access, state IDLE:
  - dmem_req=1 combinationally, with dmem_we=mem_wr, dmem_addr, dmem_be and dmem_wdata.
  - Byte lanes: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111.
  - Store data is replicated across lanes (byte x4, half x2).
- Request hold: req, we, addr, be and wdata stay stable until dmem_gnt. EX/MEM is frozen by mem_stall, so the inputs are stable.
- Store:
  - Completes in the dmem_gnt cycle: wb_valid=1, mem_stall=0, next state IDLE.
  - No gnt: go to REQ, mem_stall=1.
- Load:
  - On dmem_gnt, latch funct3 and addr[1:0], go to WAIT.
  - No gnt: go to REQ.
  - mem_stall=1 in every cycle before dmem_rvalid.
  - WAIT and dmem_rvalid: read_data = selected byte/half/word, sign- or zero-extended per latched funct3; wb_valid=1, mem_stall=0, next state IDLE.
  - Minimum load latency is 2 cycles (gnt in cycle 0, rvalid in cycle 1).
- dmem_rvalid in the same cycle as gnt is not supported and is ignored.
- read_data=0 whenever the current cycle is not a load completion.
- ex_valid=0: no request; wb_valid=0; reg_wrt_out=0.
- A single outstanding access only; no new request while in WAIT.

Optional Feature:
- Macro: LSU_STATS_EN.
- Defined:
  - Adds outputs stat_loads, stat_stores, stat_stall_cycles (STAT_W each).
  - Counters increment on load completion, on store completion, and on each mem_stall=1 cycle.
  - Counters clear on reset and wrap at 2^STAT_W.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - lsu_state_t enum (IDLE, REQ, WAIT).
  - rslt_src encodings shared with mewb and the WB mux.
- One combinational sub-module, lsu_align: store byte-enable/wdata generation and load extraction/extension.

Test Plan:
- Store word: sw, alu_addr=0x100, store_data=0xDEADBEEF, gnt in the same cycle -> dmem_be=1111, wdata=0xDEADBEEF, wb_valid=1, no stall cycle.
- Load byte signed: lb, addr=0x103, gnt cycle 0, rvalid cycle 1, rdata=0x80123456 -> read_data=0xFFFFFF80, exactly one mem_stall cycle.
- Load half unsigned, delayed grant: lhu, addr=0x102, gnt delayed 3 cycles, rvalid 2 cycles later, rdata=0xBEEF1234 -> request stable 4 cycles, read_data=0x0000BEEF, mem_stall=1 for 5 cycles.
- Misaligned: lw at addr=0x101 -> no dmem_req, misalign_exc one-cycle pulse, reg_wrt_out=0.
- Reset mid-access: rst_n low while in WAIT, then stray rvalid -> FSM in IDLE, wb_valid=0, stray rvalid ignored.
- Store byte lanes: sb, addr=0x102, store_data=0x000000AB -> dmem_be=0100, wdata=0xABABABAB.
